// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection and bubble
//   insertion. Sits between decode/register-file read and execute. The
//   ex_rs* outputs feed the EX-stage forwarding network. The stall output
//   tells the PC and IF/ID registers to hold.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   id_*                        decoded instruction fields (valid, pc, rs1/rs2,
//                               uses_rs1/rs2, rd, operand values, imm, ctrl,
//                               mem_read, reg_wen)
//   flush                       kill the instruction entering EX
//   ex_hold                     downstream stall: freeze EX
//   wb_wen, wb_rd, wb_d         writeback port (refresh during hold, bypass)
//   ex_*                        registered copies of the id_* fields
//   stall                       combinational: upstream must hold
//   bubble_cnt                  saturating count of load-use bubbles
//
// Configuration
//   WB_BYPASS_EN  when defined, a WB write to a source register in the same
//                 cycle as capture is bypassed into ex_rsN_val, so the
//                 register file need not be write-first.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [WORD_WIDTH-1:0] id_pc,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic [WORD_WIDTH-1:0] id_rs1_val,
    input  logic [WORD_WIDTH-1:0] id_rs2_val,
    input  logic [WORD_WIDTH-1:0] id_imm,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic                  id_mem_read,
    input  logic                  id_reg_wen,
    input  logic                  flush,
    input  logic                  ex_hold,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [WORD_WIDTH-1:0] wb_d,
    output logic                  ex_valid,
    output logic [WORD_WIDTH-1:0] ex_pc,
    output logic [ADDR_WIDTH-1:0] ex_rs1,
    output logic [ADDR_WIDTH-1:0] ex_rs2,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic [WORD_WIDTH-1:0] ex_rs1_val,
    output logic [WORD_WIDTH-1:0] ex_rs2_val,
    output logic [WORD_WIDTH-1:0] ex_imm,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic                  ex_mem_read,
    output logic                  ex_reg_wen,
    output logic                  stall,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  load_use;
    logic                  wb_live;
    logic                  refresh_rs1;
    logic                  refresh_rs2;
    logic [WORD_WIDTH-1:0] cap_rs1_val;
    logic [WORD_WIDTH-1:0] cap_rs2_val;

    // A load in EX whose result is needed by the instruction in ID cannot be
    // forwarded in time; x0 never creates a dependency.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Flush overrides everything: the redirected fetch must not be held.
    assign stall = !flush && (ex_hold || load_use);

    assign wb_live     = wb_wen && (wb_rd != '0);
    assign refresh_rs1 = wb_live && (wb_rd == ex_rs1);
    assign refresh_rs2 = wb_live && (wb_rd == ex_rs2);

`ifdef WB_BYPASS_EN
    assign cap_rs1_val = (wb_live && (wb_rd == id_rs1)) ? wb_d : id_rs1_val;
    assign cap_rs2_val = (wb_live && (wb_rd == id_rs2)) ? wb_d : id_rs2_val;
`else
    // Register file is write-first, so the read data is already current.
    assign cap_rs1_val = id_rs1_val;
    assign cap_rs2_val = id_rs2_val;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
            ex_mem_read <= 1'b0;
            ex_reg_wen  <= 1'b0;
            bubble_cnt  <= '0;
        end else if (flush) begin
            // Only the side-effect fields are killed; the rest is don't-care.
            ex_valid    <= 1'b0;
            ex_reg_wen  <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_rd       <= '0;
        end else if (ex_hold) begin
            // A WB result retiring while EX is frozen would otherwise be lost
            // once it leaves the forwarding window.
            if (ex_valid) begin
                if (refresh_rs1) ex_rs1_val <= wb_d;
                if (refresh_rs2) ex_rs2_val <= wb_d;
            end
        end else if (load_use) begin
            // Bubble; ID is re-presented next cycle because stall is high.
            // The load then sits in MEM, so its data reaches the consumer via
            // MEM/WB forwarding and exactly one bubble is ever needed.
            ex_valid    <= 1'b0;
            ex_reg_wen  <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_rs1_val  <= cap_rs1_val;
            ex_rs2_val  <= cap_rs2_val;
            ex_imm      <= id_imm;
            ex_ctrl     <= id_ctrl;
            ex_mem_read <= id_mem_read;
            ex_reg_wen  <= id_reg_wen;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage. The counter is built narrow so that
//   saturation is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int AW = 5;
    localparam int WW = 32;
    localparam int CW = 16;
    localparam int NW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [WW-1:0] id_pc;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_uses_rs1, id_uses_rs2;
    logic [WW-1:0] id_rs1_val, id_rs2_val, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          id_mem_read, id_reg_wen;
    logic          flush, ex_hold, wb_wen;
    logic [AW-1:0] wb_rd;
    logic [WW-1:0] wb_d;
    logic          ex_valid;
    logic [WW-1:0] ex_pc;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [WW-1:0] ex_rs1_val, ex_rs2_val, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic          ex_mem_read, ex_reg_wen, stall;
    logic [NW-1:0] bubble_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_wen(id_reg_wen),
        .flush(flush), .ex_hold(ex_hold), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_d(wb_d),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
        .ex_reg_wen(ex_reg_wen), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WW-1:0] pc, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic u1, input logic u2,
                         input logic mrd, input logic wen, input logic [CW-1:0] ctrl,
                         input logic [WW-1:0] v1, input logic [WW-1:0] v2, input logic [WW-1:0] imm);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_mem_read = mrd; id_reg_wen = wen;
        id_ctrl = ctrl; id_rs1_val = v1; id_rs2_val = v2; id_imm = imm;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_val = 0; id_rs2_val = 0;
        id_imm = 0; id_ctrl = 0; id_mem_read = 0; id_reg_wen = 0;
        flush = 0; ex_hold = 0; wb_wen = 0; wb_rd = 0; wb_d = 0;
        #12;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_cnt",   32'(bubble_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // lw x5, 4(x1)
        drive(32'h100, 5'd1, 5'd2, 5'd5, 1, 0, 1, 1, 16'h1234, 32'hA, 32'hB, 32'h4);
        tick();
        chk("cap_valid", 32'(ex_valid), 32'd1);
        chk("cap_pc",    ex_pc, 32'h100);
        chk("cap_rd",    32'(ex_rd), 32'd5);
        chk("cap_mrd",   32'(ex_mem_read), 32'd1);
        chk("cap_ctrl",  32'(ex_ctrl), 32'h1234);
        chk("cap_rs1v",  ex_rs1_val, 32'hA);
        chk("cap_imm",   ex_imm, 32'h4);

        // add x6, x5, x1 -> one bubble
        drive(32'h104, 5'd5, 5'd1, 5'd6, 1, 1, 0, 1, 16'h5555, 32'h50, 32'h10, 32'h0);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("bub_valid", 32'(ex_valid), 32'd0);
        chk("bub_rd",    32'(ex_rd), 32'd0);
        chk("bub_ctrl",  32'(ex_ctrl), 32'd0);
        chk("bub_mrd",   32'(ex_mem_read), 32'd0);
        chk("bub_wen",   32'(ex_reg_wen), 32'd0);
        chk("bub_cnt",   32'(bubble_cnt), 32'd1);
        chk("bub_stall", 32'(stall), 32'd0);
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_pc",    ex_pc, 32'h104);
        chk("add_rd",    32'(ex_rd), 32'd6);
        chk("add_cnt",   32'(bubble_cnt), 32'd1);

        // No false stall: rs2 matches but is not used
        drive(32'h108, 5'd1, 5'd2, 5'd5, 1, 0, 1, 1, 16'h0001, 32'h0, 32'h0, 32'h0);
        tick();
        drive(32'h10C, 5'd1, 5'd5, 5'd6, 1, 0, 0, 1, 16'h0002, 32'h1, 32'h2, 32'h0);
        #1;
        chk("nofalse_stall", 32'(stall), 32'd0);
        id_uses_rs2 = 1'b1;
        #1;
        chk("rs2_stall", 32'(stall), 32'd1);
        id_uses_rs2 = 1'b0;
        #1;
        tick();
        chk("nofalse_pc",  ex_pc, 32'h10C);
        chk("nofalse_cnt", 32'(bubble_cnt), 32'd1);

        // Load to x0 never creates a hazard
        drive(32'h110, 5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 16'h0003, 32'h0, 32'h0, 32'h0);
        tick();
        drive(32'h114, 5'd0, 5'd0, 5'd6, 1, 1, 0, 1, 16'h0004, 32'h0, 32'h0, 32'h0);
        #1;
        chk("x0_stall", 32'(stall), 32'd0);
        tick();
        chk("x0_pc", ex_pc, 32'h114);

        // Flush beats load-use
        drive(32'h118, 5'd1, 5'd2, 5'd5, 1, 0, 1, 1, 16'h0005, 32'h0, 32'h0, 32'h0);
        tick();
        drive(32'h11C, 5'd5, 5'd1, 5'd6, 1, 1, 0, 1, 16'h0006, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_rd",    32'(ex_rd), 32'd0);
        chk("fl_mrd",   32'(ex_mem_read), 32'd0);
        chk("fl_wen",   32'(ex_reg_wen), 32'd0);
        chk("fl_cnt",   32'(bubble_cnt), 32'd1);
        chk("fl_pc",    ex_pc, 32'h118);

        // Hold with WB refresh of rs2
        drive(32'h200, 5'd4, 5'd7, 5'd9, 1, 1, 0, 1, 16'h00FF, 32'h44, 32'h77, 32'h8);
        tick();
        drive(32'h204, 5'd7, 5'd7, 5'd10, 1, 1, 0, 1, 16'hAAAA, 32'h1, 32'h2, 32'h3);
        ex_hold = 1'b1;
        wb_wen = 1'b1; wb_rd = 5'd7; wb_d = 32'hDEADBEEF;
        #1;
        chk("hold_stall", 32'(stall), 32'd1);
        tick();
        chk("hold_rs2v",  ex_rs2_val, 32'hDEADBEEF);
        chk("hold_rs1v",  ex_rs1_val, 32'h44);
        chk("hold_pc",    ex_pc, 32'h200);
        chk("hold_rd",    32'(ex_rd), 32'd9);
        chk("hold_imm",   ex_imm, 32'h8);
        chk("hold_ctrl",  32'(ex_ctrl), 32'h00FF);
        chk("hold_valid", 32'(ex_valid), 32'd1);
        chk("hold_rs2",   32'(ex_rs2), 32'd7);

        // Capture with simultaneous WB to rs1
        ex_hold = 1'b0;
        drive(32'h300, 5'd3, 5'd8, 5'd11, 1, 1, 0, 1, 16'h0007, 32'h11, 32'h88, 32'h0);
        wb_wen = 1'b1; wb_rd = 5'd3; wb_d = 32'h22;
        tick();
        wb_wen = 1'b0;
`ifdef WB_BYPASS_EN
        chk("byp_rs1v", ex_rs1_val, 32'h22);
`else
        chk("byp_rs1v", ex_rs1_val, 32'h11);
`endif
        chk("byp_rs2v", ex_rs2_val, 32'h88);

        // Saturation of the bubble counter
        exp_cnt = 1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h400, 5'd1, 5'd2, 5'd5, 1, 0, 1, 1, 16'h0008, 32'h0, 32'h0, 32'h0);
            tick();
            drive(32'h404, 5'd5, 5'd1, 5'd6, 1, 1, 0, 1, 16'h0009, 32'h0, 32'h0, 32'h0);
            tick();
            if (exp_cnt < 7) exp_cnt++;
            chk($sformatf("sat_cnt%0d", i), 32'(bubble_cnt), 32'(exp_cnt));
        end
        tick();
        chk("sat_valid", 32'(ex_valid), 32'd1);

        // Async reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_pc",    ex_pc, 32'h0);
        chk("arst_rs2v",  ex_rs2_val, 32'h0);
        chk("arst_cnt",   32'(bubble_cnt), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        #1;
        rst_n = 1'b1;
        drive(32'h500, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 16'h000A, 32'h5, 32'h6, 32'h7);
        tick();
        chk("rst_cap_valid", 32'(ex_valid), 32'd1);
        chk("rst_cap_pc",    ex_pc, 32'h500);
        chk("rst_cap_cnt",   32'(bubble_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
